// File: rtl/mem_arbiter_2x256x16_if.sv
// Requester-side bus bundle for the two ports of mem_arbiter_2x256x16.
// master = requester view, slave = arbiter view.
interface mem_arbiter_2x256x16_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_lock;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_lock;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata
    );
endinterface

// File: rtl/mem_arbiter_2x256x16.sv
// Round-robin arbiter with bounded lock sharing one Memory_256x16 port
// between two requesters; one access per granted cycle, registered read return.
module mem_arbiter_2x256x16 #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int LOCK_MAX = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    mem_arbiter_2x256x16_if.slave     bus,
    output logic [AW-1:0]             ADDR,
    output logic                      En,
    output logic [DW-1:0]             WD,
    input  logic [DW-1:0]             RD
);
    localparam logic [7:0] LMAX = LOCK_MAX[7:0];

    typedef enum logic [1:0] {
        ST_RR    = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } own_t;

    own_t          r_state;
    own_t          w_state_nxt;
    logic [7:0]    r_lcnt;
    logic [7:0]    w_lcnt_nxt;
    logic [7:0]    w_lcnt_inc;
    logic          r_ptr;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_break;
    logic          w_rr;
    logic          w_rd0;
    logic          w_rd1;

    assign w_lcnt_inc = (r_lcnt == 8'hFF) ? r_lcnt : r_lcnt + 8'd1;

    // A lock owner that drops req is arbitrated as RR in that same cycle.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_break     = 1'b0;
        w_rr        = 1'b0;
        w_state_nxt = r_state;
        w_lcnt_nxt  = r_lcnt;
        if (!RST) begin
            w_rr = (r_state == ST_RR)
                || (r_state == ST_LOCK0 && !bus.m0_req)
                || (r_state == ST_LOCK1 && !bus.m1_req);
            if (w_rr) begin
                if (bus.m0_req && bus.m1_req) begin
                    w_gnt0 = r_ptr;
                    w_gnt1 = !r_ptr;
                end else begin
                    w_gnt0 = bus.m0_req;
                    w_gnt1 = bus.m1_req;
                end
            end else if (r_state == ST_LOCK0) begin
                if (r_lcnt < LMAX || !bus.m1_req) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1  = 1'b1;
                    w_break = 1'b1;
                end
            end else begin
                if (r_lcnt < LMAX || !bus.m0_req) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0  = 1'b1;
                    w_break = 1'b1;
                end
            end

            if (w_gnt0) begin
                if (bus.m0_lock && !w_break) begin
                    w_state_nxt = ST_LOCK0;
                    w_lcnt_nxt  = (r_state == ST_LOCK0) ? w_lcnt_inc : 8'd1;
                end else begin
                    w_state_nxt = ST_RR;
                    w_lcnt_nxt  = '0;
                end
            end else if (w_gnt1) begin
                if (bus.m1_lock && !w_break) begin
                    w_state_nxt = ST_LOCK1;
                    w_lcnt_nxt  = (r_state == ST_LOCK1) ? w_lcnt_inc : 8'd1;
                end else begin
                    w_state_nxt = ST_RR;
                    w_lcnt_nxt  = '0;
                end
            end else begin
                w_state_nxt = ST_RR;
                w_lcnt_nxt  = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_RR;
            r_lcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lcnt  <= w_lcnt_nxt;
        end
    end

    assign w_rd0 = w_gnt0 && !bus.m0_we;
    assign w_rd1 = w_gnt1 && !bus.m1_we;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr     <= 1'b1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            if (w_gnt0) begin
                r_ptr <= 1'b0;
            end else if (w_gnt1) begin
                r_ptr <= 1'b1;
            end
            r_rvalid0 <= w_rd0;
            r_rvalid1 <= w_rd1;
            if (w_rd0) begin
                r_rdata0 <= RD;
            end
            if (w_rd1) begin
                r_rdata1 <= RD;
            end
        end
    end

    assign ADDR = w_gnt1 ? bus.m1_addr  : bus.m0_addr;
    assign WD   = w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
    assign En   = (w_gnt0 && bus.m0_we) || (w_gnt1 && bus.m1_we);

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.m0_rvalid = r_rvalid0;
    assign bus.m1_rvalid = r_rvalid1;
    assign bus.m0_rdata  = r_rdata0;
    assign bus.m1_rdata  = r_rdata1;
endmodule
